channel_dispatch: RTL and testbench

Parametrised multi-channel up/down command dispatcher, successor to the two-channel Channel block. Captures a request strobe together with a one-hot channel select and an Up/Down direction, then validates and queues the command. Each queued command is replayed as a fixed-length drive pulse on the selected channel's up or down output, followed by a break-before-make gap. It sits between the user-input front end (switches, buttons) and the per-channel actuator drivers.

---
 rtl/channel_dispatch.sv | 178 +++++++++++++++++
 tb/tb_channel_dispatch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_dispatch.sv
// Multi-channel up/down command dispatcher: synchronizes and validates request strobes,
// queues commands in a small FIFO and replays each as a fixed-length drive pulse plus gap.
module channel_dispatch #(
    parameter int NUM_CH       = 2,
    parameter int PULSE_CYCLES = 16,
    parameter int GAP_CYCLES   = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [NUM_CH-1:0]               Ch,
    input  logic                            Up,
    input  logic                            Down,
    input  logic                            request,
    output logic [NUM_CH-1:0]               Ch_up,
    output logic [NUM_CH-1:0]               Ch_down,
    output logic                            busy,
    output logic                            err,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int IW      = $clog2(NUM_CH);
    localparam int CW      = IW + 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    logic [NUM_CH-1:0] ch_meta, ch_sync;
    logic              up_meta, up_sync, down_meta, down_sync;
    logic              req_meta, req_sync, req_prev;

    logic              rise, cmd_valid, full, empty, push, pop, reject, drop;
    logic [IW-1:0]     cmd_idx;
    logic [CW-1:0]     cmd_in;

    logic [CW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_next;

    state_t            state, state_next;
    logic [TW-1:0]     cnt, cnt_next;
    logic [CW-1:0]     cmd, cmd_next;
    logic [NUM_CH-1:0] up_next, down_next;
    logic              busy_next;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ch_meta   <= '0;
            ch_sync   <= '0;
            up_meta   <= 1'b0;
            up_sync   <= 1'b0;
            down_meta <= 1'b0;
            down_sync <= 1'b0;
            req_meta  <= 1'b0;
            req_sync  <= 1'b0;
            req_prev  <= 1'b0;
        end else begin
            ch_meta   <= Ch;
            ch_sync   <= ch_meta;
            up_meta   <= Up;
            up_sync   <= up_meta;
            down_meta <= Down;
            down_sync <= down_meta;
            req_meta  <= request;
            req_sync  <= req_meta;
            req_prev  <= req_sync;
        end
    end

    // A command is valid only with exactly one channel and exactly one direction.
    always_comb begin
        cmd_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sync[i]) cmd_idx = IW'(i);
        end
        cmd_in    = {cmd_idx, up_sync};
        rise      = req_sync & ~req_prev;
        cmd_valid = (ch_sync != '0) && ((ch_sync & (ch_sync - NUM_CH'(1))) == '0)
                    && (up_sync ^ down_sync);
        full      = (fifo_level == FULL_LEVEL);
        empty     = (fifo_level == '0);
        push      = rise & cmd_valid & ~full;
        drop      = rise & cmd_valid & full;
        reject    = (rise & ~cmd_valid) | drop;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_next   = cmd;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cmd_next   = mem[rd_ptr];
                    cnt_next   = PULSE_LOAD;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    cnt_next   = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt - TW'(1);
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - TW'(1);
                end else if (!empty) begin
                    pop        = 1'b1;
                    cmd_next   = mem[rd_ptr];
                    cnt_next   = PULSE_LOAD;
                    state_next = DRIVE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        level_next = fifo_level;
        if (push && !pop) level_next = fifo_level + LW'(1);
        else if (!push && pop) level_next = fifo_level - LW'(1);

        // Outputs are computed from the next state so they register on the transition edge.
        up_next   = '0;
        down_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            up_next[i]   = (state_next == DRIVE) &&  cmd_next[0] && (cmd_next[CW-1:1] == IW'(i));
            down_next[i] = (state_next == DRIVE) && !cmd_next[0] && (cmd_next[CW-1:1] == IW'(i));
        end
        busy_next = (state_next != IDLE) || (level_next != '0);
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            Ch_up      <= '0;
            Ch_down    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            cmd        <= cmd_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_level <= level_next;
            Ch_up      <= up_next;
            Ch_down    <= down_next;
            busy       <= busy_next;
            err        <= reject;
            overflow   <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_channel_dispatch.sv
// Directed bench for channel_dispatch: a negedge monitor compares each drive pulse
// against a queue of expected pulses pushed when the command is issued.
module tb_channel_dispatch;

    localparam int NUM_CH = 2;
    localparam int PULSE  = 4;
    localparam int GAP    = 2;
    localparam int DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ch;
    logic        up, down, request;
    logic [1:0]  ch_up, ch_down;
    logic        busy, err, overflow;
    logic [1:0]  fifo_level;

    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  exp_q[$];
    int          starts[$];
    int          ncyc = 0;
    bit          in_pulse = 0;
    logic [3:0]  pulse_val = '0;
    int          pulse_len = 0;
    int          pulse_count = 0;
    int          pc0, sidx;

    channel_dispatch #(
        .NUM_CH(NUM_CH), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clk(clk), .Reset(rst_n), .Ch(ch), .Up(up), .Down(down), .request(request),
        .Ch_up(ch_up), .Ch_down(ch_down), .busy(busy), .err(err),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic end_pulse();
        logic [3:0] e;
        pulse_count++;
        if (exp_q.size() == 0) begin
            check_output("pulse_unexpected", 32'(pulse_val), 0);
        end else begin
            e = exp_q.pop_front();
            check_output("pulse_value", 32'(pulse_val), 32'(e));
        end
        check_output("pulse_width", pulse_len, PULSE);
    endtask

    // Pulses are tracked as {Ch_up, Ch_down}; a reset aborts the pulse in flight.
    always @(negedge clk) begin : monitor
        logic [3:0] val;
        ncyc++;
        val = {ch_up, ch_down};
        if (!rst_n) begin
            in_pulse = 0;
        end else if (val != 4'b0000) begin
            check_output("drive_onehot", 32'($countones(val)), 1);
            if (!in_pulse) begin
                in_pulse = 1; pulse_val = val; pulse_len = 1; starts.push_back(ncyc);
            end else if (val == pulse_val) begin
                pulse_len++;
            end else begin
                end_pulse();
                pulse_val = val; pulse_len = 1; starts.push_back(ncyc);
            end
        end else if (in_pulse) begin
            end_pulse();
            in_pulse = 0;
        end
    end

    // Returns at the negedge after edge 1 + hold - 1.
    task automatic apply_stimulus(input logic [1:0] c, input logic u, input logic d, input int hold);
        ch = c; up = u; down = d;
        tick(2);
        request = 1'b1;
        tick(hold);
        request = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tick(1);
        check_output(tag, 32'(busy), 0);
    endtask

    task automatic invalid_case(input string tag, input logic [1:0] c, input logic u, input logic d);
        apply_stimulus(c, u, d, 1);
        tick(2);
        check_output({tag, "_err"}, 32'(err), 1);
        tick(1);
        check_output({tag, "_err_once"}, 32'(err), 0);
        check_output({tag, "_level"}, 32'(fifo_level), 0);
        check_output({tag, "_ovf"}, 32'(overflow), 0);
        tick(8);
        check_output({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; ch = 2'b00; up = 1'b0; down = 1'b0; request = 1'b0;
        tick(3);
        check_output("rst_ch_up", 32'(ch_up), 0);
        check_output("rst_ch_down", 32'(ch_down), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_err", 32'(err), 0);
        check_output("rst_overflow", 32'(overflow), 0);
        check_output("rst_level", 32'(fifo_level), 0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] single up command on channel 0");
        exp_q.push_back(4'b0100);
        apply_stimulus(2'b01, 1'b1, 1'b0, 1);
        tick(2);
        check_output("t1_level_e3", 32'(fifo_level), 1);
        check_output("t1_busy_e3", 32'(busy), 1);
        check_output("t1_no_drive_e3", 32'(ch_up), 0);
        tick(1);
        check_output("t1_drive_e4", 32'(ch_up), 1);
        check_output("t1_level_e4", 32'(fifo_level), 0);
        wait_idle("t1_idle");

        $display("[TB] request held high on channel 1 down");
        pc0 = pulse_count;
        exp_q.push_back(4'b0010);
        apply_stimulus(2'b10, 1'b0, 1'b1, 20);
        wait_idle("t2_idle");
        check_output("t2_one_pulse", pulse_count - pc0, 1);
        check_output("t2_level", 32'(fifo_level), 0);

        $display("[TB] invalid commands");
        invalid_case("inv_two_ch", 2'b11, 1'b1, 1'b0);
        invalid_case("inv_no_ch", 2'b00, 1'b1, 1'b0);
        invalid_case("inv_both_dir", 2'b01, 1'b1, 1'b1);

        // Two-cycle spacing lets the fourth command land while the FIFO holds two.
        $display("[TB] burst of four commands");
        sidx = starts.size();
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        ch = 2'b01; up = 1'b1; down = 1'b0;
        tick(2);
        request = 1'b1; tick(1); request = 1'b0; ch = 2'b10; up = 1'b0; down = 1'b1; tick(1);
        request = 1'b1; tick(1); request = 1'b0; ch = 2'b01; up = 1'b1; down = 1'b0; tick(1);
        check_output("t4_first_drive", 32'(ch_up), 1);
        request = 1'b1; tick(1);
        check_output("t4_level_one", 32'(fifo_level), 1);
        request = 1'b0; ch = 2'b10; up = 1'b0; down = 1'b1; tick(1);
        request = 1'b1; tick(1);
        check_output("t4_level_two", 32'(fifo_level), 2);
        request = 1'b0; tick(1);
        tick(1);
        check_output("t4_drop_err", 32'(err), 1);
        check_output("t4_drop_ovf", 32'(overflow), 1);
        check_output("t4_drop_level", 32'(fifo_level), 2);
        tick(1);
        check_output("t4_err_once", 32'(err), 0);
        check_output("t4_ovf_sticky", 32'(overflow), 1);
        check_output("t4_level_pop", 32'(fifo_level), 1);
        check_output("t4_second_pulse", 32'(ch_down), 2);
        wait_idle("t4_idle");
        check_output("t4_pulse_count", starts.size() - sidx, 3);
        if (starts.size() - sidx >= 3) begin
            check_output("t4_period_1", starts[sidx+1] - starts[sidx], PULSE + GAP);
            check_output("t4_period_2", starts[sidx+2] - starts[sidx+1], PULSE + GAP);
        end
        check_output("t4_ovf_after", 32'(overflow), 1);

        $display("[TB] reset during drive with one command queued");
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        ch = 2'b01; up = 1'b1; down = 1'b0;
        tick(2);
        request = 1'b1; tick(1); request = 1'b0; ch = 2'b10; tick(1);
        request = 1'b1; tick(1); request = 1'b0; tick(1);
        tick(1);
        check_output("t5_drive_2nd", 32'(ch_up), 1);
        check_output("t5_queued", 32'(fifo_level), 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("t5_async_up", 32'(ch_up), 0);
        check_output("t5_async_down", 32'(ch_down), 0);
        check_output("t5_async_level", 32'(fifo_level), 0);
        check_output("t5_async_busy", 32'(busy), 0);
        exp_q.delete();
        tick(2);
        ch = 2'b00; up = 1'b0;
        rst_n = 1'b1;
        pc0 = pulse_count;
        tick(1);
        check_output("t5_level_after", 32'(fifo_level), 0);
        check_output("t5_ovf_cleared", 32'(overflow), 0);
        tick(15);
        check_output("t5_no_resume", pulse_count - pc0, 0);
        check_output("t5_busy_after", 32'(busy), 0);

        $display("[TB] push on the same edge as gap-to-drive pop");
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        ch = 2'b01; up = 1'b1; down = 1'b0;
        tick(2);
        request = 1'b1; tick(1); request = 1'b0; ch = 2'b10; up = 1'b0; down = 1'b1; tick(1);
        request = 1'b1; tick(1); request = 1'b0; ch = 2'b10; up = 1'b1; down = 1'b0; tick(4);
        request = 1'b1; tick(1); request = 1'b0; tick(1);
        check_output("t6_level_before", 32'(fifo_level), 1);
        tick(1);
        check_output("t6_level_same", 32'(fifo_level), 1);
        check_output("t6_second_drive", 32'(ch_down), 2);
        check_output("t6_no_err", 32'(err), 0);
        wait_idle("t6_idle");
        check_output("t6_level_end", 32'(fifo_level), 0);

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
